// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered operand stage feeding the ALU.
// Holds up to two decoded entries (MAIN drives the ALU, SKID absorbs one
// extra entry under backpressure), patches held and incoming operands with
// write-back data, and can be flushed on a taken branch.
module alu_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  data1_i,
  input  logic [WIDTH-1:0]  data2_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [CTRL_W-1:0] ALUCtrl_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [WIDTH-1:0]  wb_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  data1_o,
  output logic [WIDTH-1:0]  data2_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic [REG_AW-1:0] rd_o
);

  typedef struct packed {
    logic [WIDTH-1:0]  data1;
    logic [WIDTH-1:0]  data2;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rd;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q;
  entry_t in_e, in_f, main_f, skid_f;
  logic   acc, pop;

  // Replace an operand with write-back data when its source register is
  // being written this cycle; register 0 is never a real source.
  function automatic entry_t forward(input entry_t e,
                                     input logic wb_en,
                                     input logic [REG_AW-1:0] wb_rd,
                                     input logic [WIDTH-1:0] wb_data);
    entry_t r;
    r = e;
    if (wb_en && (wb_rd != '0)) begin
      if (e.rs1 == wb_rd) r.data1 = wb_data;
      if (e.rs2 == wb_rd) r.data2 = wb_data;
    end
    return r;
  endfunction

  // Handshake terms and forwarded views of every entry that may be written.
  always_comb begin
    in_e   = '{data1: data1_i, data2: data2_i, rs1: rs1_i, rs2: rs2_i,
               ctrl: ALUCtrl_i, rd: rd_i};
    acc    = valid_i & ready_o;
    pop    = valid_o & ready_i;
    in_f   = forward(in_e, wb_en_i, wb_rd_i, wb_data_i);
    main_f = forward(main_q, wb_en_i, wb_rd_i, wb_data_i);
    skid_f = forward(skid_q, wb_en_i, wb_rd_i, wb_data_i);
  end

  // State register; ready_o is registered from the next state.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    if (!rst_i) begin
      state_q <= EMPTY;
      ready_o <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_o <= (state_d != TWO);
    end
  end

  // Next-state logic; flush wins over accept and pop.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:   if (acc) state_d = ONE;
        ONE:     if (!acc && pop) state_d = EMPTY;
                 else if (acc && !pop) state_d = TWO;
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output decode: MAIN always drives the ALU inputs.
  always_comb begin
    valid_o   = (state_q != EMPTY);
    data1_o   = main_q.data1;
    data2_o   = main_q.data2;
    ALUCtrl_o = main_q.ctrl;
    rd_o      = main_q.rd;
  end

  // Entry storage: held entries pick up forwarding every edge, then
  // accept/pop moves data between input, SKID and MAIN in arrival order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      // NOTE: only MAIN is cleared because it is visible on the outputs;
      // SKID is never read while empty, so it carries no reset.
      main_q <= '0;
    end else if (!flush_i) begin
      main_q <= main_f;
      skid_q <= skid_f;
      case (state_q)
        EMPTY: if (acc) main_q <= in_f;
        ONE: begin
          if (acc && pop) main_q <= in_f;
          else if (acc)   skid_q <= in_f;
        end
        TWO:     if (pop) main_q <= skid_f;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: a queue-based reference model tracks the
// entries the stage should hold; a monitor compares the DUT against it on
// every falling edge.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] data1_in = '0, data2_in = '0;
  logic [4:0]  rs1_in = '0, rs2_in = '0, rd_in = '0;
  logic [2:0]  ctrl_in = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [31:0] data1_out, data2_out;
  logic [2:0]  ctrl_out;
  logic [4:0]  rd_out;

  alu_operand_stage #(.WIDTH(32), .CTRL_W(3), .REG_AW(5)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .valid_i(valid_in), .ready_o(ready_out),
    .data1_i(data1_in), .data2_i(data2_in),
    .rs1_i(rs1_in), .rs2_i(rs2_in), .ALUCtrl_i(ctrl_in), .rd_i(rd_in),
    .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .valid_o(valid_out), .ready_i(ready_in),
    .data1_o(data1_out), .data2_o(data2_out),
    .ALUCtrl_o(ctrl_out), .rd_o(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
  } ent_t;

  ent_t sb[$];          // entries the stage should hold, oldest first
  bit   ready_m = 1'b1; // model of the registered ready
  bit   started = 1'b0; // set once the first reset edge has happened
  bit   clean   = 1'b0; // no entry accepted since reset: outputs must be 0
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t patch(input ent_t e);
    ent_t r;
    r = e;
    if (wb_en && wb_rd != 5'd0) begin
      if (e.rs1 == wb_rd) r.d1 = wb_data;
      if (e.rs2 == wb_rd) r.d2 = wb_data;
    end
    return r;
  endfunction

  // Reference model: advances the held-entry queue at each rising edge.
  // Pops have already been taken by the monitor on the preceding falling edge.
  initial begin
    forever begin
      ent_t e;
      bit   acc;
      @(posedge clk);
      if (!rst) begin
        sb.delete();
        ready_m = 1'b1;
        clean   = 1'b1;
        started = 1'b1;
      end else if (flush) begin
        sb.delete();
        ready_m = 1'b1;
      end else begin
        acc = valid_in && ready_m;
        foreach (sb[i]) sb[i] = patch(sb[i]);
        if (acc) begin
          e = '{d1: data1_in, d2: data2_in, rs1: rs1_in, rs2: rs2_in,
                ctrl: ctrl_in, rd: rd_in};
          sb.push_back(patch(e));
          clean = 1'b0;
        end
        ready_m = (sb.size() < 2);
      end
    end
  end

  // Monitor: compares handshake and head entry; consumes the head on a pop.
  initial begin
    forever begin
      ent_t e;
      @(negedge clk);
      if (started) begin
        check("ready_o", ready_out, ready_m);
        check("valid_o", valid_out, sb.size() != 0);
        if (sb.size() != 0) begin
          if (ready_in) e = sb.pop_front();
          else          e = sb[0];
          check("data1_o", data1_out, e.d1);
          check("data2_o", data2_out, e.d2);
          check("ALUCtrl_o", ctrl_out, e.ctrl);
          check("rd_o", rd_out, e.rd);
        end else if (clean) begin
          check("reset_outputs", {data1_out, data2_out, ctrl_out, rd_out}, '0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d1, input logic [31:0] d2,
                      input logic [2:0] ctrl, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd);
    valid_in = 1'b1;
    data1_in = d1;
    data2_in = d2;
    ctrl_in  = ctrl;
    rs1_in   = rs1;
    rs2_in   = rs2;
    rd_in    = rd;
  endtask

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin
    // Reset held for two cycles with valid asserted.
    rst = 1'b0;
    send(32'h11, 32'h22, 3'b001, 5'd0, 5'd0, 5'd1);
    tick(); tick();
    rst = 1'b1;
    valid_in = 1'b0;
    tick();

    // Streaming with the ALU always ready.
    ready_in = 1'b1;
    send(32'd5, 32'd3, 3'b010, 5'd0, 5'd0, 5'd2); tick();
    send(32'd7, 32'd2, 3'b001, 5'd0, 5'd0, 5'd3); tick();
    valid_in = 1'b0;
    tick(); tick();

    // Backpressure: A, B fill the stage, C is held off until it drains.
    ready_in = 1'b0;
    send(32'd1, 32'd1, 3'b001, 5'd0, 5'd0, 5'd4); tick();
    send(32'd2, 32'd2, 3'b001, 5'd0, 5'd0, 5'd5); tick();
    send(32'd3, 32'd3, 3'b011, 5'd0, 5'd0, 5'd6); tick(); tick(); tick();
    ready_in = 1'b1;
    tick(); tick();
    valid_in = 1'b0;
    tick(); tick(); tick();

    // Forwarding onto a held head, then a write-back to register 0.
    ready_in = 1'b0;
    send(32'h10, 32'h20, 3'b100, 5'd4, 5'd0, 5'd7); tick();
    valid_in = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hABCD; tick();
    wb_rd = 5'd0; wb_data = 32'h5555; tick();
    wb_en = 1'b0;
    ready_in = 1'b1;
    tick(); tick();

    // Flush while full, with a new input presented in the same cycle.
    ready_in = 1'b0;
    send(32'hA1, 32'hA2, 3'b101, 5'd0, 5'd0, 5'd8); tick();
    send(32'hB1, 32'hB2, 3'b101, 5'd0, 5'd0, 5'd9); tick();
    send(32'hDEAD, 32'hBEEF, 3'b010, 5'd0, 5'd0, 5'd10);
    flush = 1'b1; tick();
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    tick(); tick();

    // Reset mid-stream while full; the next entry must emerge alone.
    ready_in = 1'b0;
    send(32'hC1, 32'hC2, 3'b001, 5'd0, 5'd0, 5'd11); tick();
    send(32'hD1, 32'hD2, 3'b001, 5'd0, 5'd0, 5'd12); tick();
    valid_in = 1'b0;
    rst = 1'b0; tick();
    rst = 1'b1;
    ready_in = 1'b1;
    send(32'hE1, 32'hE2, 3'b011, 5'd0, 5'd0, 5'd13); tick();
    valid_in = 1'b0;
    tick(); tick();

    // Randomized traffic with frequent forwarding hits and rare flush/reset.
    for (int n = 0; n < 3000; n++) begin
      send($urandom, $urandom, 3'($urandom_range(1, 5)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 2) != 0);
      wb_en    = $urandom_range(0, 1) != 0;
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      flush    = ($urandom_range(0, 31) == 0);
      rst      = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; wb_en = 1'b0; ready_in = 1'b1;
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
